// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue_if
// Description : IF->ID fetch-queue handshake bundle (producer and consumer side).
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int EXC_W   = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic [EXC_W-1:0]   in_except;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [EXC_W-1:0]   out_except;

    // Queue side
    modport slave (
        input  in_valid, in_pc, in_instr, in_except, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_except
    );

    // Fetch stage / ID stage side
    modport master (
        output in_valid, in_pc, in_instr, in_except, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_except
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Circular FIFO decoupling IF from ID; optional zero-latency
//               empty-queue bypass enabled by macro IFQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int EXC_W   = 32
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    input  wire logic                       flush,
    if_fetch_queue_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_ENT_W = PC_W + INSTR_W + EXC_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_in_ent;
    logic [c_ENT_W-1:0] w_head;

    assign w_in_ent = {bus.in_pc, bus.in_instr, bus.in_except};
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_empty & bus.in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry taken by ID in the same cycle never touches storage
    assign w_pop  = ~w_empty & bus.out_ready & ~flush;
    assign w_push = bus.in_valid & ~w_full & ~flush & ~(w_bypass & bus.out_ready);

    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[r_rptr];
        end else if (w_bypass) begin
            w_head = w_in_ent;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty | w_bypass;
    assign {bus.out_pc, bus.out_instr, bus.out_except} = w_head;
    assign count = r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in_ent;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Scoreboard bench for if_fetch_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;
    localparam int DEPTH = 4;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic [2:0] count;

    if_fetch_queue_if #(.PC_W(32), .INSTR_W(32), .EXC_W(32)) bus ();

    if_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .EXC_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus.slave),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [95:0] sb[$];

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] exc,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = pc ^ 32'h1357_9BDF;
        bus.in_except = exc;
        bus.out_ready = rdy;
        flush         = fl;
    endtask

    function automatic logic [95:0] exp_head();
        if (sb.size() != 0) return sb[0];
`ifdef IFQ_BYPASS_EN
        if (bus.in_valid && !flush) return {bus.in_pc, bus.in_instr, bus.in_except};
`endif
        return '0;
    endfunction

    function automatic logic exp_valid();
`ifdef IFQ_BYPASS_EN
        return (sb.size() != 0) || (bus.in_valid && !flush);
`else
        return sb.size() != 0;
`endif
    endfunction

    // Called at the negative edge: applies this cycle's handshakes to the model, then advances
    task automatic commit();
        bit bp;
        bit pop;
        bit push;
        bp = 1'b0;
`ifdef IFQ_BYPASS_EN
        bp = (sb.size() == 0) && bus.in_valid && !flush;
`endif
        if (flush) begin
            sb.delete();
        end else begin
            pop  = bus.out_ready && (sb.size() != 0);
            push = bus.in_valid && (sb.size() != DEPTH) && !(bp && bus.out_ready);
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back({bus.in_pc, bus.in_instr, bus.in_except});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if ({bus.out_pc, bus.out_instr, bus.out_except} !== 96'd0) begin
            n_errors++; $display("FAIL reset_out_data: got %h expected 0", {bus.out_pc, bus.out_instr, bus.out_except}); end
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0500 + 32'(i * 4), 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            commit();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL async_reset_count: got %0d expected 0", count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL async_reset_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL async_reset_ready: got %b expected 1", bus.in_ready); end
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_0100 + 32'(i * 4), (i == 2) ? 32'h0000_0004 : 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++; if (bus.in_ready !== (sb.size() != DEPTH)) begin
                n_errors++; $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, bus.in_ready, sb.size() != DEPTH); end
            commit();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_full_ready: got %b expected 0", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            @(negedge clk);
            n_checks++; if (bus.out_pc !== 32'h0000_0100 + 32'(i * 4)) begin
                n_errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'h0000_0100 + 32'(i * 4)); end
            n_checks++; if ({bus.out_pc, bus.out_instr, bus.out_except} !== exp_head()) begin
                n_errors++; $display("FAIL drain_entry[%0d]: got %h expected %h", i, {bus.out_pc, bus.out_instr, bus.out_except}, exp_head()); end
            commit();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0) begin
            n_errors++; $display("FAIL drain_empty: got valid=%b pc=%h expected valid=0 pc=0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hBFC0_0000 + 32'(i * 4), (i == 6) ? 32'h8000_0001 : 32'd0, 1'b1, 1'b0);
            @(negedge clk);
            n_checks++; if (bus.out_valid !== exp_valid() || {bus.out_pc, bus.out_instr, bus.out_except} !== exp_head()) begin
                n_errors++; $display("FAIL wrap_head[%0d]: got v=%b %h expected v=%b %h", i, bus.out_valid,
                    {bus.out_pc, bus.out_instr, bus.out_except}, exp_valid(), exp_head()); end
            n_checks++; if (count !== 3'(sb.size())) begin
                n_errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, sb.size()); end
            commit();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== exp_valid() || bus.out_pc !== exp_head()[95:64]) begin
            n_errors++; $display("FAIL wrap_tail: got v=%b pc=%h expected v=%b pc=%h", bus.out_valid, bus.out_pc, exp_valid(), exp_head()[95:64]); end
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(i * 4), 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            commit();
        end
        drive(1'b1, 32'hDEAD_0000, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        n_checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_state: got count=%0d valid=%b expected count=0 valid=0", count, bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0 || bus.out_pc === 32'hDEAD_0000) begin
                n_errors++; $display("FAIL flush_leak[%0d]: got valid=%b pc=%h expected valid=0", i, bus.out_valid, bus.out_pc); end
            commit();
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_4000 + 32'(i * 4), 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            commit();
        end
        drive(1'b1, 32'h0000_2000, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL fpp_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_pc !== 32'h0000_4000) begin n_errors++; $display("FAIL fpp_head: got %h expected 00004000", bus.out_pc); end
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL fpp_count: got %0d expected 3", count); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== exp_valid() || bus.out_pc !== exp_head()[95:64]) begin
                n_errors++; $display("FAIL fpp_drain[%0d]: got v=%b pc=%h expected v=%b pc=%h", i, bus.out_valid, bus.out_pc,
                    exp_valid(), exp_head()[95:64]); end
            commit();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000) begin
            n_errors++; $display("FAIL bypass_same_cycle: got v=%b pc=%h expected v=1 pc=80000000", bus.out_valid, bus.out_pc); end
`else
        n_checks++; if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL nobypass_same_cycle: got v=%b expected 0", bus.out_valid); end
`endif
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        n_checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bypass_after: got count=%0d v=%b expected count=0 v=0", count, bus.out_valid); end
`else
        n_checks++; if (count !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000) begin
            n_errors++; $display("FAIL nobypass_after: got count=%0d v=%b pc=%h expected count=1 v=1 pc=80000000",
                count, bus.out_valid, bus.out_pc); end
`endif
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_full_push_pop();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
